// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - funct3 load/store encodings, LSU state encoding and size decode helpers.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } lsu_state_t;

   // Reserved encodings (011, 110, 111) fall through to word.
   function automatic logic is_byte(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_BU);
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return (f3 == F3_H) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  f3,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'(rdata >> {offset, 3'b000});
      lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         F3_B:    data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   data = {24'h0, lane_b};
         F3_H:    data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   data = {16'h0, lane_h};
         F3_W:    data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding data memory load/store unit with bus timeout.
// Optional MISALIGN_TRAP_EN: reject misaligned halfword/word accesses with a misalign pulse.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] aluResIn,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] storeData,
   input  logic [4:0]  rdIn,
   input  logic        regWriteIn,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWdata,
   output logic [3:0]  dmemBe,
   input  logic        dmemReady,
   input  logic [31:0] dmemRdata,
   output logic        stall,
   output logic [31:0] wbData,
   output logic [4:0]  wbRd,
   output logic        wbRegWrite,
   output logic        busErr,
   output logic        misalign
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   lsu_state_t  state, state_nxt;
   logic [31:0] addr_q, data_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic        rw_q, store_q;
   logic [7:0]  cnt;
   logic        mem_op, misal;
   logic [31:0] load_data;

   assign mem_op = memRead | memWrite;

`ifdef MISALIGN_TRAP_EN
   assign misal = mem_op &&
                  ((is_half(funct3) && aluResIn[0]) ||
                   (!is_byte(funct3) && !is_half(funct3) && (aluResIn[1:0] != 2'b00)));
`else
   assign misal = 1'b0;
`endif

   // Combinational controls are gated by rst so an abandoned access drops off the bus at once.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      busErr    = 1'b0;
      misalign  = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !rst) begin
               if (misal) begin
                  misalign = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (dmemReady) begin
               state_nxt = IDLE;
            end else if (cnt == TO_LAST) begin
               state_nxt = IDLE;
               busErr    = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
      endcase
   end

   assign dmemReq  = (state == BUSY);
   assign dmemWe   = (state == BUSY) && store_q;
   assign dmemAddr = {addr_q[31:2], 2'b00};

   always_comb begin
      dmemBe    = 4'b1111;
      dmemWdata = data_q;
      if (store_q) begin
         if (is_byte(f3_q)) begin
            dmemBe    = 4'b0001 << addr_q[1:0];
            dmemWdata = {4{data_q[7:0]}};
         end else if (is_half(f3_q)) begin
            dmemBe    = 4'b0011 << {addr_q[1], 1'b0};
            dmemWdata = {2{data_q[15:0]}};
         end
      end
   end

   load_align u_load_align (
      .rdata  (dmemRdata),
      .offset (addr_q[1:0]),
      .f3     (f3_q),
      .data   (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         rw_q       <= 1'b0;
         store_q    <= 1'b0;
         cnt        <= '0;
         wbData     <= '0;
         wbRd       <= '0;
         wbRegWrite <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (!mem_op) begin
                  wbData     <= aluResIn;
                  wbRd       <= rdIn;
                  wbRegWrite <= regWriteIn;
               end else if (misal) begin
                  wbRegWrite <= 1'b0;
               end else begin
                  addr_q  <= aluResIn;
                  data_q  <= storeData;
                  f3_q    <= funct3;
                  rd_q    <= rdIn;
                  rw_q    <= regWriteIn;
                  store_q <= memWrite;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               if (dmemReady) begin
                  if (store_q) begin
                     wbRegWrite <= 1'b0;
                  end else begin
                     wbData     <= load_data;
                     wbRd       <= rd_q;
                     wbRegWrite <= rw_q;
                  end
               end else if (cnt == TO_LAST) begin
                  wbRegWrite <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule
